// File: rtl/vga_timing_gen.sv
// vga_timing_gen: counter-based 640x480@60 raster engine for the ADV7123 DAC path.
// Runs from CLOCK_50 with a 25 MHz pixel enable. Publishes col/row to the pixel
// generators and registers their colour together with sync/blank one pixel later.
// Optional build macro VGA_TESTBARS_EN adds test_en, which swaps the returned colour
// for eight vertical colour bars.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
`ifdef VGA_TESTBARS_EN
    input  logic        test_en,
`endif
    input  logic [9:0]  red,
    input  logic [9:0]  green,
    input  logic [9:0]  blue,
    output logic [10:0] col,
    output logic [10:0] row,
    output logic        frame_start,
    output logic [9:0]  oVGA_R,
    output logic [9:0]  oVGA_G,
    output logic [9:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK,
    output logic        oVGA_CLOCK
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HLast  = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLast  = 11'(V_TOTAL - 1);
    localparam logic [10:0] HAct   = 11'(H_ACTIVE);
    localparam logic [10:0] VAct   = 11'(V_ACTIVE);
    localparam logic [10:0] HsBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HsEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VsBeg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VsEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        pix_en_q;
    logic        dac_clk_q;
    // Set by reset: the first pixel enable enters (0,0) instead of advancing.
    logic        start_q, start_d;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        fs_q, fs_d;

    logic [9:0]  r_q, g_q, b_q;
    logic        hs_q, vs_q, blank_q;
    logic [9:0]  r_px, g_px, b_px;
    logic        vis, hs_px, vs_px;

    // Raster counter next state, advancing once per pixel enable.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        start_d = start_q;
        fs_d    = 1'b0;
        if (pix_en_q) begin
            start_d = 1'b0;
            if (start_q) begin
                fs_d = 1'b1;
            end else if (h_q == HLast) begin
                h_d = '0;
                if (v_q == VLast) begin
                    v_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    v_d = v_q + 11'd1;
                end
            end else begin
                h_d = h_q + 11'd1;
            end
        end
    end

    // Pixel-stage inputs: colour gated by visibility, sync decoded from the same counts.
    always_comb begin
        vis   = (h_q < HAct) && (v_q < VAct);
        hs_px = !((h_q >= HsBeg) && (h_q < HsEnd));
        vs_px = !((v_q >= VsBeg) && (v_q < VsEnd));
        r_px  = vis ? red   : '0;
        g_px  = vis ? green : '0;
        b_px  = vis ? blue  : '0;
`ifdef VGA_TESTBARS_EN
        if (test_en) begin
            r_px = (vis && (h_q >= 11'(4 * H_ACTIVE / 8))) ? 10'h3FC : '0;
            g_px = (vis && (((h_q >= 11'(2 * H_ACTIVE / 8)) && (h_q < 11'(4 * H_ACTIVE / 8)))
                         || (h_q >= 11'(6 * H_ACTIVE / 8)))) ? 10'h3FC : '0;
            b_px = (vis && (((h_q >= 11'(H_ACTIVE / 8)) && (h_q < 11'(2 * H_ACTIVE / 8)))
                         || ((h_q >= 11'(3 * H_ACTIVE / 8)) && (h_q < 11'(4 * H_ACTIVE / 8)))
                         || ((h_q >= 11'(5 * H_ACTIVE / 8)) && (h_q < 11'(6 * H_ACTIVE / 8)))
                         || (h_q >= 11'(7 * H_ACTIVE / 8)))) ? 10'h3FC : '0;
        end
`endif
    end

    // Pixel enable, DAC clock and raster counters.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q  <= 1'b0;
            dac_clk_q <= 1'b0;
            start_q   <= 1'b1;
            h_q       <= '0;
            v_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            pix_en_q  <= ~pix_en_q;
            // DAC latches on the rising edge, which lands mid-pixel.
            dac_clk_q <= ~pix_en_q;
            start_q   <= start_d;
            h_q       <= h_d;
            v_q       <= v_d;
            fs_q      <= fs_d;
        end
    end

    // Pixel stage: colour, sync and blank registered together for alignment.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else if (pix_en_q && !start_q) begin
            r_q     <= r_px;
            g_q     <= g_px;
            b_q     <= b_px;
            hs_q    <= hs_px;
            vs_q    <= vs_px;
            blank_q <= vis;
        end
    end

    assign col         = h_q;
    assign row         = v_q;
    assign frame_start = fs_q;
    assign oVGA_R      = r_q;
    assign oVGA_G      = g_q;
    assign oVGA_B      = b_q;
    assign oVGA_HS     = hs_q;
    assign oVGA_VS     = vs_q;
    assign oVGA_BLANK  = blank_q;
    assign oVGA_CLOCK  = dac_clk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Horizontal timing is the default 800-pixel line; vertical
// timing is shortened to 10 lines (4 active, FP 2, sync 2, BP 2) to keep runs short.
// The main process pushes the expected per-pixel DAC state into a queue; a monitor
// aligned on frame_start pops and compares one entry per pixel period.
module tb_vga_timing_gen;

    localparam int unsigned HT = 800;
    localparam int unsigned VT = 10;
    localparam int unsigned FRAME = HT * VT;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
`ifdef VGA_TESTBARS_EN
    logic        test_en;
`endif
    logic [9:0]  red, green, blue;
    logic [10:0] col, row;
    logic        frame_start;
    logic [9:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK;

    int n_checks = 0;
    int n_err = 0;
    logic [56:0] exp_q[$];
    int mon_phase = 0;
    int pix_idx = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    // Pixel generator stand-in: colour derived from the published coordinate.
    assign red   = col[9:0];
    assign green = row[9:0];
    assign blue  = col[9:0] ^ row[9:0];

    vga_timing_gen #(
        .V_ACTIVE(4),
        .V_FP(2),
        .V_SYNC(2),
        .V_BP(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
`ifdef VGA_TESTBARS_EN
        .test_en(test_en),
`endif
        .red(red),
        .green(green),
        .blue(blue),
        .col(col),
        .row(row),
        .frame_start(frame_start),
        .oVGA_R(oVGA_R),
        .oVGA_G(oVGA_G),
        .oVGA_B(oVGA_B),
        .oVGA_HS(oVGA_HS),
        .oVGA_VS(oVGA_VS),
        .oVGA_BLANK(oVGA_BLANK),
        .oVGA_CLOCK(oVGA_CLOCK)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected DAC/raster state sampled just after the edge that presents pixel n.
    // Fields: R,G,B,HS,VS,BLANK,DACCLK,frame_start,col,row (col/row are pixel n+1).
    function automatic logic [56:0] model(input int unsigned n, input bit bars);
        int unsigned h, v, hn, vn, bar;
        logic [9:0] r, g, b;
        logic vis, hs, vs, fs;
        h   = n % HT;
        v   = (n / HT) % VT;
        hn  = (n + 1) % HT;
        vn  = ((n + 1) / HT) % VT;
        vis = (h < 640) && (v < 4);
        hs  = !((h >= 656) && (h < 752));
        vs  = !((v >= 6) && (v < 8));
        fs  = (hn == 0) && (vn == 0);
        r   = vis ? 10'(h) : 10'd0;
        g   = vis ? 10'(v) : 10'd0;
        b   = vis ? 10'(h ^ v) : 10'd0;
        if (bars) begin
            bar = h / 80;
            r = (vis && bar >= 4) ? 10'h3FC : 10'd0;
            g = (vis && (bar % 4) >= 2) ? 10'h3FC : 10'd0;
            b = (vis && (bar % 2) == 1) ? 10'h3FC : 10'd0;
        end
        return {r, g, b, hs, vs, vis, 1'b0, fs, 11'(hn), 11'(vn)};
    endfunction

    task automatic push_pixels(input int unsigned count, input bit bars);
        for (int unsigned i = 0; i < count; i++) exp_q.push_back(model(i, bars));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int left;
        left = budget;
        while (exp_q.size() != 0 && left > 0) begin
            @(posedge CLOCK_50);
            left--;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: %0d expected pixels never presented", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_dac"},
              {54'd0, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK,
               frame_start},
              {54'd0, 30'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        check({name, "_colrow"}, {42'd0, col, row}, 64'd0);
    endtask

    // Monitor: sync on frame_start, then one comparison per pixel period.
    always @(posedge CLOCK_50) begin
        #1;
        if (reset) begin
            mon_phase = 0;
        end else begin
            case (mon_phase)
                0: if (frame_start) begin
                    mon_phase = 1;
                    pix_idx = 0;
                end
                1: mon_phase = 2;
                2: begin
                    if (exp_q.size() == 0) begin
                        mon_phase = 4;
                    end else begin
                        check($sformatf("pixel%0d", pix_idx),
                              {7'd0, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK,
                               oVGA_CLOCK, frame_start, col, row},
                              {7'd0, exp_q.pop_front()});
                        pix_idx++;
                        mon_phase = 3;
                    end
                end
                3: begin
                    check("dacclk_mid", {62'd0, oVGA_CLOCK, frame_start}, 64'd2);
                    mon_phase = 2;
                end
                default: ;
            endcase
        end
    end

    initial begin
        int left;
        reset = 1'b1;
`ifdef VGA_TESTBARS_EN
        test_en = 1'b0;
`endif
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_reset_state("por");

        // Frame 1 in full, then into frame 2 up to row 3.
        @(posedge CLOCK_50);
        #2 reset = 1'b0;
        push_pixels(FRAME + 3 * HT + 200, 1'b0);
        wait_drain("drain_a", 2 * (FRAME + 3 * HT + 200) + 100);

        // Mid-frame asynchronous reset at col=300,row=3.
        left = 2000;
        while (!(col == 11'd300 && row == 11'd3) && left > 0) begin
            @(posedge CLOCK_50);
            #1;
            left--;
        end
        check("reach_300_3", {42'd0, col, row}, {42'd0, 11'd300, 11'd3});
        #1 reset = 1'b1;
        #1 check_reset_state("async_rst");
        repeat (5) @(posedge CLOCK_50);
        #1 check_reset_state("rst_hold");
        exp_q.delete();
        #1 reset = 1'b0;
        push_pixels(FRAME + 1, 1'b0);
        wait_drain("drain_b", 2 * (FRAME + 1) + 100);

`ifdef VGA_TESTBARS_EN
        @(posedge CLOCK_50);
        #2 reset = 1'b1;
        test_en = 1'b1;
        exp_q.delete();
        @(posedge CLOCK_50);
        #2 reset = 1'b0;
        push_pixels(HT, 1'b1);
        wait_drain("drain_bars", 2 * HT + 100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
